fetch_unit: RTL and testbench

//  Fetch-side producer for the F->D pipeline register: owns the fetch PC and requests instructions from imem.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/fetch_unit.sv | 188 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the fetch stage.
//   NOP_INSTR         : instruction shown to decode when nothing has been fetched
//   RESET_PC_DEFAULT  : default fetch PC after reset
//   fetch_entry_t     : one prefetch FIFO entry {pc, instr}
// The entry fields are 32 bits wide; fetch_unit is meant to be built with
// DATA_WIDTH = 32.
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int unsigned FETCH_XLEN       = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO of fetch_entry_t holding prefetched instructions.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write an entry (caller guarantees the FIFO is not full)
//   pop        : drop the head entry (caller guarantees the FIFO is not empty)
//   flush      : empty the FIFO; overrides push and pop in the same cycle
//   head       : current head entry (undefined content when empty)
//   count      : number of stored entries (0..DEPTH)
//   empty      : count == 0
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;

  // Storage, pointers and occupancy; flush clears occupancy ahead of push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Fetch-side producer for the F->D pipeline register. Owns the fetch PC,
// issues word requests to imem, buffers in-order responses in a prefetch FIFO
// and presents the FIFO head (or a NOP bubble) to decode.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   stallF                : hold current output, do not pop
//   PCSrcE, PCTargetE     : redirect strobe and target from Execute
//   imem_req, imem_addr   : request valid / word address
//   imem_ready            : imem accepts the request this cycle
//   imem_rvalid/rdata     : in-order response, latency >= 1
//   instr, PCounterF,
//   PCPlus4F, validF      : presented instruction, its PC, PC+4, real/bubble
// Optional (macro FETCH_PERF_EN):
//   perf_fetched          : count of instructions handed to decode
//   perf_bubbles          : cycles with !validF && !stallF
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stallF,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] PCounterF,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  output logic                  validF
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_bubbles
`endif
);

  localparam int unsigned           CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]           DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [DATA_WIDTH-1:0] last_pc_q, last_pc_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  fetch_entry_t          fifo_head;
  fetch_entry_t          push_entry;
  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [CW:0]           credit_used;
  logic [CW-1:0]         rvalid_dec;
  logic [DATA_WIDTH-1:0] redirect_pc;

  // Credits cover both in-flight requests and buffered entries, so a response
  // always finds room in the FIFO. rst_n gates the request during reset.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign imem_req    = rst_n && !PCSrcE && (credit_used < DEPTH_C);
  assign imem_addr   = pc_q;
  assign issue       = imem_req && imem_ready;

  assign rvalid_dec  = {{(CW-1){1'b0}}, imem_rvalid};
  assign redirect_pc = {PCTargetE[DATA_WIDTH-1:2], 2'b00};

  // Responses still owed to a flushed path are discarded via drop_cnt.
  assign push       = imem_rvalid && (drop_cnt_q == '0);
  assign push_entry = '{pc: resp_pc_q, instr: imem_rdata};
  assign validF     = !fifo_empty;
  assign pop        = validF && !stallF;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (PCSrcE),
    .wdata (push_entry),
    .head  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // Presented instruction: FIFO head, or a NOP with the last shown PC held.
  always_comb begin
    instr     = NOP_INSTR;
    PCounterF = last_pc_q;
    if (fifo_empty) begin
      instr     = NOP_INSTR;
      PCounterF = last_pc_q;
    end else begin
      instr     = fifo_head.instr;
      PCounterF = fifo_head.pc;
    end
    PCPlus4F  = PCounterF + PC_STEP;
    last_pc_d = PCounterF;
  end

  // Next-state for fetch PC, response PC, credits and drop counter.
  always_comb begin
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    if (PCSrcE) begin
      // Every request still in flight after this cycle belongs to the old path.
      pc_d          = redirect_pc;
      resp_pc_d     = redirect_pc;
      outstanding_d = outstanding_q - rvalid_dec;
      drop_cnt_d    = outstanding_q - rvalid_dec;
    end else begin
      if (issue) begin
        pc_d = pc_q + PC_STEP;
      end else begin
        pc_d = pc_q;
      end
      case ({issue, imem_rvalid})
        2'b10:   outstanding_d = outstanding_q + CW'(1);
        2'b01:   outstanding_d = outstanding_q - CW'(1);
        default: outstanding_d = outstanding_q;
      endcase
      if (imem_rvalid) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
        end else begin
          resp_pc_d = resp_pc_q + PC_STEP;
        end
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end
  end

  // Fetch-side state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      last_pc_q     <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      last_pc_q     <= last_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_bubbles_q;

  // Performance counters; a pop cancelled by a same-cycle redirect is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= 32'd0;
      perf_bubbles_q <= 32'd0;
    end else begin
      if (pop && !PCSrcE) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (!validF && !stallF) begin
        perf_bubbles_q <= perf_bubbles_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. A queue-based imem responder supplies
// in-order responses with a programmable latency. A transaction-level model
// tracks in-flight requests (tagged stale on redirect) and the prefetch
// queue; every cycle the DUT outputs are compared against it at the negedge.
// Literal expectations pin key cycles of the directed scenarios.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stallF = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr, PCounterF, PCPlus4F;
  logic        validF;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stallF      (stallF),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .PCounterF   (PCounterF),
    .PCPlus4F    (PCPlus4F),
    .validF      (validF)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles)
`endif
  );

  // imem environment
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend_q[$];
  int    cyc = 0;
  int    lat = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // reference model
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  typedef struct { logic [31:0] addr; bit stale; } req_t;
  ent_t        m_fifo[$];
  req_t        m_infl[$];
  logic [31:0] m_pc, m_last_pc;
  int unsigned m_fetched, m_bubbles;

  // values captured at the last sample point, for literal checks
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    pend_q.delete();
    m_fifo.delete();
    m_infl.delete();
    m_pc      = 32'h0;
    m_last_pc = 32'h0;
    m_fetched = 0;
    m_bubbles = 0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    stallF      = 1'b0;
    PCSrcE      = 1'b0;
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    #1;
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_validF", validF, 1'b0);
    check("rst_instr", instr, NOP);
    check("rst_PCounterF", PCounterF, 32'h0);
    check("rst_PCPlus4F", PCPlus4F, 32'h4);
`ifdef FETCH_PERF_EN
    check("rst_perf_fetched", perf_fetched, 32'h0);
    check("rst_perf_bubbles", perf_bubbles, 32'h0);
`endif
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare at negedge, advance model and imem.
  task automatic run_cycle(input bit stall, input bit redir, input logic [31:0] tgt, input bit rdy);
    bit          m_valid, m_exp_req, accept;
    logic [31:0] m_pc_out, m_instr;
    ent_t        e;
    req_t        r;
    pend_t       p;
    stallF     = stall;
    PCSrcE     = redir;
    PCTargetE  = tgt;
    imem_ready = rdy;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    @(negedge clk);
    m_valid  = (m_fifo.size() != 0);
    m_pc_out = m_last_pc;
    m_instr  = NOP;
    if (m_valid) begin
      m_pc_out = m_fifo[0].pc;
      m_instr  = m_fifo[0].ins;
    end
    m_exp_req = !redir && ((m_infl.size() + m_fifo.size()) < DEPTH);
    check("validF", validF, m_valid);
    check("instr", instr, m_instr);
    check("PCounterF", PCounterF, m_pc_out);
    check("PCPlus4F", PCPlus4F, m_pc_out + 32'd4);
    check("imem_req", imem_req, m_exp_req);
    if (m_exp_req) check("imem_addr", imem_addr, m_pc);
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_bubbles", perf_bubbles, m_bubbles);
`endif
    s_req = imem_req; s_addr = imem_addr; s_valid = validF;
    s_pc = PCounterF; s_instr = instr;
    // advance model
    accept = m_exp_req && rdy;
    if (m_valid) m_last_pc = m_fifo[0].pc;
    if (!m_valid && !stall) m_bubbles++;
    if (redir) begin
      m_fifo.delete();
      if (imem_rvalid && m_infl.size() > 0) r = m_infl.pop_front();
      foreach (m_infl[i]) m_infl[i].stale = 1'b1;
      m_pc = {tgt[31:2], 2'b00};
    end else begin
      if (m_valid && !stall) begin
        e = m_fifo.pop_front();
        m_fetched++;
      end
      if (imem_rvalid && m_infl.size() > 0) begin
        r = m_infl.pop_front();
        if (!r.stale) m_fifo.push_back('{r.addr, imem_rdata});
      end
      if (accept) begin
        m_infl.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    if (imem_rvalid) p = pend_q.pop_front();
    if (s_req && rdy) pend_q.push_back('{s_addr, cyc + lat});
    cyc++;
  endtask

  initial begin
    bit found;
    imem_ready = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // 1: reset release, ready = 1, latency 1
    lat = 1;
    run_cycle(0, 0, 32'h0, 1);
    check("t1_req_c1", s_req, 1'b1);
    check("t1_addr_c1", s_addr, 32'h0);
    check("t1_valid_c1", s_valid, 1'b0);
    run_cycle(0, 0, 32'h0, 1);
    check("t1_addr_c2", s_addr, 32'h4);
    run_cycle(0, 0, 32'h0, 1);
    check("t1_valid_c3", s_valid, 1'b1);
    check("t1_pc_c3", s_pc, 32'h0);
    check("t1_instr_c3", s_instr, 32'hDEAD_0000);
    run_cycle(0, 0, 32'h0, 1);
    check("t1_pc_c4", s_pc, 32'h4);
    run_cycle(0, 0, 32'h0, 1);
    check("t1_valid_c5", s_valid, 1'b0);
    run_cycle(0, 0, 32'h0, 1);
    check("t1_pc_c6", s_pc, 32'h8);
    repeat (4) run_cycle(0, 0, 32'h0, 1);

    // 2: stall until the FIFO is full, then resume
    repeat (6) run_cycle(1, 0, 32'h0, 1);
    check("t2_req_stalled_full", s_req, 1'b0);
    check("t2_valid_stalled", s_valid, 1'b1);
    repeat (8) run_cycle(0, 0, 32'h0, 1);

    // 3: redirect with two requests outstanding (latency 3)
    do_reset();
    lat = 3;
    run_cycle(0, 0, 32'h0, 1);
    run_cycle(0, 0, 32'h0, 1);
    run_cycle(0, 1, 32'h0000_0103, 1);
    check("t3_req_redirect", s_req, 1'b0);
    run_cycle(0, 0, 32'h0, 1);
    check("t3_valid_c4", s_valid, 1'b0);
    run_cycle(0, 0, 32'h0, 1);
    check("t3_req_c5", s_req, 1'b1);
    check("t3_addr_c5", s_addr, 32'h0000_0100);
    repeat (3) run_cycle(0, 0, 32'h0, 1);
    check("t3_valid_c8", s_valid, 1'b0);
    run_cycle(0, 0, 32'h0, 1);
    check("t3_valid_c9", s_valid, 1'b1);
    check("t3_pc_c9", s_pc, 32'h0000_0100);
    check("t3_instr_c9", s_instr, 32'hDEAD_0100);
    repeat (6) run_cycle(0, 0, 32'h0, 1);

    // 4: imem not ready for 5 cycles -> FIFO drains to a NOP bubble
    lat = 1;
    repeat (6) run_cycle(0, 0, 32'h0, 1);
    repeat (5) run_cycle(0, 0, 32'h0, 0);
    check("t4_valid_drained", s_valid, 1'b0);
    check("t4_instr_nop", s_instr, NOP);
    repeat (5) run_cycle(0, 0, 32'h0, 1);

    // 5: redirect in a cycle with rvalid and a pop
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_fifo.size() != 0 && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        found = 1'b1;
        run_cycle(0, 1, 32'h0000_0200, 1);
      end else begin
        run_cycle(0, 0, 32'h0, 1);
      end
    end
    check("t5_scenario_reached", found, 1'b1);
    run_cycle(0, 0, 32'h0, 1);
    check("t5_valid_after_flush", s_valid, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      run_cycle(0, 0, 32'h0, 1);
      if (s_valid) begin
        found = 1'b1;
        check("t5_first_pc", s_pc, 32'h0000_0200);
      end
    end
    check("t5_valid_seen", found, 1'b1);

    // wrap-around across 32'hFFFF_FFFC and mixed stall pattern
    run_cycle(0, 1, 32'hFFFF_FFFA, 1);
    for (int i = 0; i < 24; i++) begin
      run_cycle((i % 5) == 2 || (i % 7) == 4, 0, 32'h0, (i % 6) != 3);
    end

    // 6: counters clear on reset, then run again
    do_reset();
    lat = 2;
    for (int i = 0; i < 20; i++) begin
      run_cycle((i % 4) == 1, 0, 32'h0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
